// File: rtl/wb_stage_pkg.sv
// Shared constants and types for the writeback stage: bank port widths,
// the fixed vector-byte register index and the stage FSM encoding.
package wb_stage_pkg;

  localparam int RG_W = 4;
  localparam int DC_W = 32;
  localparam int DV_W = 8;

  localparam logic [RG_W-1:0] VREG_IDX = 4'hF;

  typedef enum logic {
    ACCEPT = 1'b0,
    SPLIT  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_stage_counter.sv
// Free-running wrap-around event counter; counts one per cycle with i_inc set.
// Latency 1 cycle (registered count); never stalls.
module wb_stage_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: drives register-bank scalar/vector write ports, latency 1.
// A scalar+vector write to VREG is split over two cycles, in_ready drops for the second.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [RG_W-1:0] VREG  = VREG_IDX,
  parameter int              RET_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RG_W-1:0]  in_rd,
  input  logic [DC_W-1:0]  in_data,
  input  logic             in_we_c,
  input  logic             in_we_v,
  input  logic [DV_W-1:0]  in_byte,
  output logic [RG_W-1:0]  Rg_WB,
  output logic [DC_W-1:0]  DinC,
  output logic             WE_C,
  output logic [DV_W-1:0]  DinV_8bit,
  output logic             WE_V,
  output logic             fwd_valid,
  output logic [RG_W-1:0]  fwd_rd,
  output logic [DC_W-1:0]  fwd_data,
  output logic [RET_W-1:0] retired_count
);

  wb_state_t       r_state, w_state_nxt;
  logic            r_ready, w_ready;
  logic            r_we_c, w_we_c;
  logic            r_we_v, w_we_v;
  logic [RG_W-1:0] r_rg, w_rg;
  logic [DC_W-1:0] r_dinc, w_dinc;
  logic [DV_W-1:0] r_dinv, w_dinv;
  logic [DV_W-1:0] r_pend, w_pend;

  logic w_xfer;
  logic w_conflict;

  assign w_xfer     = in_valid && r_ready;
  assign w_conflict = in_we_c && in_we_v && (in_rd == VREG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCEPT;
      r_ready <= 1'b0;
      r_we_c  <= 1'b0;
      r_we_v  <= 1'b0;
      r_rg    <= '0;
      r_dinc  <= '0;
      r_dinv  <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready;
      r_we_c  <= w_we_c;
      r_we_v  <= w_we_v;
      r_rg    <= w_rg;
      r_dinc  <= w_dinc;
      r_dinv  <= w_dinv;
      r_pend  <= w_pend;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCEPT:  if (w_xfer && w_conflict) w_state_nxt = SPLIT;
      SPLIT:   w_state_nxt = ACCEPT;
      default: w_state_nxt = ACCEPT;
    endcase
  end

  // Next values for the registered outputs; address/data hold when idle.
  always_comb begin
    w_ready = 1'b1;
    w_we_c  = 1'b0;
    w_we_v  = 1'b0;
    w_rg    = r_rg;
    w_dinc  = r_dinc;
    w_dinv  = r_dinv;
    w_pend  = r_pend;
    case (r_state)
      ACCEPT: begin
        if (w_xfer) begin
          w_we_c = in_we_c;
          w_rg   = in_rd;
          w_dinc = in_data;
          if (w_conflict) begin
            // Scalar goes first so VREG ends as {byte, 24'b0}.
            w_pend  = in_byte;
            w_ready = 1'b0;
          end else begin
            w_we_v = in_we_v;
            w_dinv = in_byte;
          end
        end
      end
      SPLIT: begin
        w_we_v = 1'b1;
        w_dinv = r_pend;
      end
      default: ;
    endcase
  end

  wb_stage_counter #(.W(RET_W)) u_ret_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_xfer),
    .o_count (retired_count)
  );

  assign in_ready  = r_ready;
  assign WE_C      = r_we_c;
  assign WE_V      = r_we_v;
  assign Rg_WB     = r_rg;
  assign DinC      = r_dinc;
  assign DinV_8bit = r_dinv;
  assign fwd_valid = r_we_c;
  assign fwd_rd    = r_rg;
  assign fwd_data  = r_dinc;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage (RET_W=4): vector table for single-cycle
// transfers, hand sequences for the VREG split, reset mid-split and counter wrap.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rd;
  logic [31:0] in_data;
  logic        in_we_c;
  logic        in_we_v;
  logic [7:0]  in_byte;
  logic [3:0]  Rg_WB;
  logic [31:0] DinC;
  logic        WE_C;
  logic [7:0]  DinV_8bit;
  logic        WE_V;
  logic        fwd_valid;
  logic [3:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [3:0]  retired_count;

  always #5 clk = ~clk;

  wb_stage #(.VREG(4'hF), .RET_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .in_we_c(in_we_c), .in_we_v(in_we_v), .in_byte(in_byte),
    .Rg_WB(Rg_WB), .DinC(DinC), .WE_C(WE_C), .DinV_8bit(DinV_8bit), .WE_V(WE_V),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retired_count(retired_count)
  );

  typedef struct {
    logic        v;
    logic [3:0]  rd;
    logic [31:0] d;
    logic        c;
    logic        vv;
    logic [7:0]  b;
    logic        e_rdy;
    logic        e_wec;
    logic        e_wev;
    logic [3:0]  e_rg;
    logic [31:0] e_dinc;
    logic [7:0]  e_dinv;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [3:0] m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] rd, input logic [31:0] d,
                       input logic c, input logic vv, input logic [7:0] b);
    in_valid = v; in_rd = rd; in_data = d; in_we_c = c; in_we_v = vv; in_byte = b;
  endtask

  task automatic chk_all(input string t, input logic rdy, input logic wec, input logic wev,
                         input logic [3:0] rg, input logic [31:0] dinc, input logic [7:0] dinv);
    chk({t, ".in_ready"},  {31'd0, in_ready}, {31'd0, rdy});
    chk({t, ".WE_C"},      {31'd0, WE_C}, {31'd0, wec});
    chk({t, ".WE_V"},      {31'd0, WE_V}, {31'd0, wev});
    chk({t, ".Rg_WB"},     {28'd0, Rg_WB}, {28'd0, rg});
    chk({t, ".DinC"},      DinC, dinc);
    chk({t, ".DinV"},      {24'd0, DinV_8bit}, {24'd0, dinv});
    chk({t, ".fwd_valid"}, {31'd0, fwd_valid}, {31'd0, wec});
    chk({t, ".fwd_rd"},    {28'd0, fwd_rd}, {28'd0, rg});
    chk({t, ".fwd_data"},  fwd_data, dinc);
    chk({t, ".count"},     {28'd0, retired_count}, {28'd0, m_cnt});
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 4'd3,  32'hDEADBEEF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd3,  32'hDEADBEEF, 8'h00};
    tbl[1] = '{1'b0, 4'd9,  32'h11111111, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 4'd3,  32'hDEADBEEF, 8'h00};
    tbl[2] = '{1'b1, 4'd2,  32'h0BADF00D, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 4'd2,  32'h0BADF00D, 8'hA5};
    tbl[3] = '{1'b1, 4'd7,  32'hCAFE0001, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 4'd7,  32'hCAFE0001, 8'h3C};
    tbl[4] = '{1'b1, 4'hF,  32'h00000000, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 4'hF,  32'h00000000, 8'h11};
    tbl[5] = '{1'b1, 4'hF,  32'h55AA55AA, 1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 4'hF,  32'h55AA55AA, 8'h22};
    tbl[6] = '{1'b1, 4'd4,  32'h00000077, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 1'b0, 4'd4,  32'h00000077, 8'h99};
    tbl[7] = '{1'b0, 4'd1,  32'hFFFFFFFF, 1'b1, 1'b0, 8'hEE, 1'b1, 1'b0, 1'b0, 4'd4,  32'h00000077, 8'h99};

    // Reset held with a valid request pending.
    m_cnt = 4'd0;
    rst_n = 1'b1;
    drive(1'b1, 4'd3, 32'h01020304, 1'b1, 1'b1, 8'h44);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 8'd0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk_all("post_reset", 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 8'd0);

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].rd, tbl[i].d, tbl[i].c, tbl[i].vv, tbl[i].b);
      step();
      if (tbl[i].v) m_cnt = m_cnt + 4'd1;
      chk_all($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_wec, tbl[i].e_wev,
              tbl[i].e_rg, tbl[i].e_dinc, tbl[i].e_dinv);
    end

    // VREG conflict: scalar first, byte next cycle, follower stalled one cycle.
    drive(1'b1, 4'hF, 32'h12345678, 1'b1, 1'b1, 8'h7F);
    step();
    m_cnt = m_cnt + 4'd1;
    chk_all("split_c1", 1'b0, 1'b1, 1'b0, 4'hF, 32'h12345678, 8'h99);
    drive(1'b1, 4'd5, 32'h0000ABCD, 1'b1, 1'b0, 8'h00);
    step();
    chk_all("split_c2", 1'b1, 1'b0, 1'b1, 4'hF, 32'h12345678, 8'h7F);
    step();
    m_cnt = m_cnt + 4'd1;
    chk_all("split_c3", 1'b1, 1'b1, 1'b0, 4'd5, 32'h0000ABCD, 8'h00);
    drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 8'h00);
    step();
    chk_all("split_idle", 1'b1, 1'b0, 1'b0, 4'd5, 32'h0000ABCD, 8'h00);

    // Reset asserted while in SPLIT drops the pending byte.
    drive(1'b1, 4'hF, 32'h89ABCDEF, 1'b1, 1'b1, 8'h5A);
    step();
    m_cnt = m_cnt + 4'd1;
    chk_all("rsplit_c1", 1'b0, 1'b1, 1'b0, 4'hF, 32'h89ABCDEF, 8'h00);
    drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    m_cnt = 4'd0;
    chk_all("rsplit_rst", 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 8'd0);
    step();
    chk("rsplit_hold.WE_V", {31'd0, WE_V}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk_all("rsplit_release", 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 8'd0);
    step();
    chk("rsplit_after.WE_V", {31'd0, WE_V}, 32'd0);

    // 17 back-to-back transfers wrap the 4-bit counter to 1.
    for (int i = 0; i < 17; i++) begin
      logic c, vv;
      c  = (i != 5);
      vv = (i % 3 == 0) && (i != 5);
      drive(1'b1, 4'(i % 15), 32'(i * 3 + 1), c, vv, 8'(i));
      step();
      m_cnt = m_cnt + 4'd1;
      chk($sformatf("wrap%0d.WE_C", i), {31'd0, WE_C}, {31'd0, c});
      chk($sformatf("wrap%0d.WE_V", i), {31'd0, WE_V}, {31'd0, vv});
      chk($sformatf("wrap%0d.ready", i), {31'd0, in_ready}, 32'd1);
    end
    drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 8'h00);
    step();
    chk("wrap_count", {28'd0, retired_count}, 32'd1);
    chk("wrap_model", {28'd0, m_cnt}, 32'd1);
    chk("wrap_idle.WE_C", {31'd0, WE_C}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
